// File: rtl/bcd_7seg_scan_driver_pkg.sv
// Shared segment definitions and the BCD to 7-segment lookup for the scan driver.
package seg7_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_ALL   = 8'hFF;

  // Codes 10..15 decode to blank, matching the 4511 behaviour.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return 7'h3F;
      4'd1:    return 7'h06;
      4'd2:    return 7'h5B;
      4'd3:    return 7'h4F;
      4'd4:    return 7'h66;
      4'd5:    return 7'h6D;
      4'd6:    return 7'h7D;
      4'd7:    return 7'h07;
      4'd8:    return 7'h7F;
      4'd9:    return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational nibble to {g,f,e,d,c,b,a} decoder, shared by all digits after the scan mux.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg7
);

  always_comb begin
    seg7 = bcd_to_seg(bcd);
  end

endmodule

// File: rtl/bcd_7seg_scan_driver.sv
// Time-multiplexed multi-digit BCD to 7-segment driver with latch, lamp test,
// blanking, anti-ghost slot blanking and leading-zero suppression.
module bcd_7seg_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYCLES   = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
)
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [4*DIGITS-1:0]         bcd_in,
  input  logic [DIGITS-1:0]           dp_in,
  input  logic                        le,
  input  logic                        lt_n,
  input  logic                        bi_n,
  input  logic                        lz_en,
  output logic [7:0]                  seg,
  output logic [DIGITS-1:0]           dig_sel,
  output logic [$clog2(DIGITS)-1:0]   scan_idx
);

  localparam int IDXW = $clog2(DIGITS);
  localparam int CNTW = $clog2(SCAN_DIV);

  localparam logic [IDXW-1:0]   IDX_LAST = IDXW'(DIGITS - 1);
  localparam logic [CNTW-1:0]   CNT_LAST = CNTW'(SCAN_DIV - 1);
  localparam logic [CNTW-1:0]   CNT_BLNK = CNTW'(BLANK_CYCLES);
  localparam logic [7:0]        SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] DIG_POL  = (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [4*DIGITS-1:0] bcd_q;
  logic [DIGITS-1:0]   dp_q;
  logic [CNTW-1:0]     div_cnt;

  logic [3:0]          cur_bcd;
  logic                cur_dp;
  logic                cur_lz;
  logic                above_zero;
  logic                slot_blank;
  logic [6:0]          dec_seg;
  logic [7:0]          seg_next;
  logic [DIGITS-1:0]   dig_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      dp_q  <= '0;
    end else if (!le) begin
      bcd_q <= bcd_in;
      dp_q  <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == CNT_LAST) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + IDXW'(1);
    end else begin
      div_cnt  <= div_cnt + CNTW'(1);
    end
  end

  // Walk from the most significant digit down so above_zero means "this and all higher digits are 0".
  always_comb begin
    cur_bcd    = 4'd0;
    cur_dp     = 1'b0;
    cur_lz     = 1'b0;
    above_zero = 1'b1;
    dig_next   = '0;
    slot_blank = (div_cnt < CNT_BLNK);
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero & (bcd_q[4*i +: 4] == 4'd0);
      if (scan_idx == IDXW'(i)) begin
        cur_bcd     = bcd_q[4*i +: 4];
        cur_dp      = dp_q[i];
        cur_lz      = above_zero & (i != 0);
        dig_next[i] = ~slot_blank;
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd  (cur_bcd),
    .seg7 (dec_seg)
  );

  always_comb begin
    seg_next = {cur_dp, dec_seg};
    if (!lt_n) begin
      seg_next = SEG_ALL;
    end else if (!bi_n) begin
      seg_next = SEG_BLANK;
    end else if (lz_en && cur_lz) begin
      seg_next         = SEG_BLANK;
      seg_next[SEG_DP] = cur_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= SEG_BLANK ^ SEG_POL;
      dig_sel <= DIG_POL;
    end else begin
      seg     <= seg_next ^ SEG_POL;
      dig_sel <= dig_next ^ DIG_POL;
    end
  end

endmodule
